// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer slice.
//   DATA_W          datapath / register width
//   OP_AND..OP_SLT  3-bit opcode encoding
//   S_IDLE..S_WB    sequencer state encoding
package alu_pkg;

  localparam int DATA_W = 16;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_LDI = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_EXEC = 2'd2;
  localparam logic [1:0] S_WB   = 2'd3;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU.
//   a, b    operands
//   imm     immediate, passed through for LDI
//   op      opcode (alu_pkg encoding)
//   result  computed value
//   carry   ADD carry-out / SUB borrow, 0 for other ops
module alu_core
  import alu_pkg::*;
#(
  parameter int DATA_W = alu_pkg::DATA_W
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  input  logic [2:0]        op,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  localparam int SH_W = $clog2(DATA_W);

  // One extra bit so the carry/borrow falls out of the same adder.
  logic [DATA_W:0] sum;

  always_comb begin
    result = '0;
    carry  = 1'b0;
    sum    = '0;
    case (op)
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_LDI: result = imm;
      OP_ADD: begin
        sum    = {1'b0, a} + {1'b0, b};
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
      end
      OP_SUB: begin
        // Top bit of the widened difference is set exactly when a < b unsigned.
        sum    = {1'b0, a} - {1'b0, b};
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
      end
      OP_SLL: result = a << b[SH_W-1:0];
      OP_SLT: result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_regfile_ctrl.sv
// Four-state sequencer around alu_core with an NREGS x DATA_W register file.
//   clk, rst                 clock, synchronous active-high reset
//   instr_valid/instr_ready  instruction handshake (op, rd, rs, rt, imm)
//   result, zero, carry      last result and flags, held between instructions
//   result_valid             one-cycle pulse in WB
//   dbg_addr/dbg_data        combinational register read port
module alu_regfile_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int NREGS  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] rd,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic              zero,
  output logic              carry,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] regs [NREGS];
  logic [1:0]        state;

  logic [2:0]        op_q;
  logic [ADDR_W-1:0] rd_q, rs_q, rt_q;
  logic [DATA_W-1:0] imm_q, a_q, b_q;

  logic [DATA_W-1:0] alu_res;
  logic              alu_carry;

  alu_core #(.DATA_W(DATA_W)) u_core (
    .a      (a_q),
    .b      (b_q),
    .imm    (imm_q),
    .op     (op_q),
    .result (alu_res),
    .carry  (alu_carry)
  );

  assign instr_ready  = (state == S_IDLE) && !rst;
  // Gated by rst so an abort landing on the WB cycle never reports a result.
  assign result_valid = (state == S_WB) && !rst;

  // R0 is forced to zero on reads; writes to it are also dropped in WB.
  assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      op_q   <= '0;
      rd_q   <= '0;
      rs_q   <= '0;
      rt_q   <= '0;
      imm_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      result <= '0;
      zero   <= 1'b0;
      carry  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (instr_valid) begin
            op_q  <= op;
            rd_q  <= rd;
            rs_q  <= rs;
            rt_q  <= rt;
            imm_q <= imm;
            state <= S_READ;
          end
        end
        S_READ: begin
          a_q   <= (rs_q == '0) ? '0 : regs[rs_q];
          b_q   <= (rt_q == '0) ? '0 : regs[rt_q];
          state <= S_EXEC;
        end
        S_EXEC: begin
          result <= alu_res;
          zero   <= (alu_res == '0);
          carry  <= alu_carry;
          state  <= S_WB;
        end
        S_WB: begin
          // Write lands at the end of WB, ahead of any following READ.
          if (rd_q != '0) regs[rd_q] <= result;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_regfile_ctrl.sv
// Directed bench for alu_regfile_ctrl: inputs driven after negedge,
// outputs sampled at negedge, expected values hand-computed.
module tb_alu_regfile_ctrl;

  localparam logic [2:0] AND_ = 3'b000, OR_ = 3'b001, XOR_ = 3'b010, LDI = 3'b011;
  localparam logic [2:0] ADD = 3'b100, SUB = 3'b101, SLL = 3'b110, SLT = 3'b111;

  logic        clk, rst;
  logic        instr_valid, instr_ready;
  logic [2:0]  op, rd, rs, rt, dbg_addr;
  logic [15:0] imm, result, dbg_data;
  logic        result_valid, zero, carry;

  int checks = 0;
  int errors = 0;

  alu_regfile_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .op           (op),
    .rd           (rd),
    .rs           (rs),
    .rt           (rt),
    .imm          (imm),
    .result       (result),
    .result_valid (result_valid),
    .zero         (zero),
    .carry        (carry),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic dbg(input string tag, input logic [2:0] a, input logic [15:0] exp);
    dbg_addr = a;
    #1;
    chk(tag, {16'h0, dbg_data}, {16'h0, exp});
  endtask

  // Present one instruction in an IDLE cycle and follow it to its WB cycle.
  task automatic run(input string tag, input logic [2:0] o, input logic [2:0] d,
                     input logic [2:0] s, input logic [2:0] t, input logic [15:0] im,
                     input logic [15:0] er, input logic ez, input logic ec);
    @(negedge clk);
    op = o; rd = d; rs = s; rt = t; imm = im; instr_valid = 1'b1;
    chk({tag, "_ready"}, {31'h0, instr_ready}, 32'd1);
    @(negedge clk);
    instr_valid = 1'b0;
    chk({tag, "_rv_read"}, {31'h0, result_valid}, 32'd0);
    @(negedge clk);
    chk({tag, "_rv_exec"}, {31'h0, result_valid}, 32'd0);
    @(negedge clk);
    chk({tag, "_rv_wb"}, {31'h0, result_valid}, 32'd1);
    chk({tag, "_res"},   {16'h0, result}, {16'h0, er});
    chk({tag, "_zero"},  {31'h0, zero},  {31'h0, ez});
    chk({tag, "_carry"}, {31'h0, carry}, {31'h0, ec});
  endtask

  initial begin
    rst = 1'b1; instr_valid = 1'b0; op = '0; rd = '0; rs = '0; rt = '0;
    imm = '0; dbg_addr = '0;

    // Reset
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rst_ready", {31'h0, instr_ready}, 32'd0);
      chk("rst_rv",    {31'h0, result_valid}, 32'd0);
    end
    chk("rst_result", {16'h0, result}, 32'd0);
    chk("rst_flags",  {30'h0, zero, carry}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {31'h0, instr_ready}, 32'd1);
    for (int a = 0; a < 8; a++) dbg("rst_dbg", a[2:0], 16'h0000);

    // Logic
    run("ldi_r1", LDI, 3'd1, 3'd0, 3'd0, 16'h00F0, 16'h00F0, 1'b0, 1'b0);
    run("ldi_r2", LDI, 3'd2, 3'd0, 3'd0, 16'h0F0F, 16'h0F0F, 1'b0, 1'b0);
    run("or_r3",  OR_, 3'd3, 3'd1, 3'd2, 16'hDEAD, 16'h0FFF, 1'b0, 1'b0);
    @(negedge clk);
    dbg("dbg_r3", 3'd3, 16'h0FFF);
    run("and_r4", AND_, 3'd4, 3'd1, 3'd2, 16'h0, 16'h0000, 1'b1, 1'b0);
    run("xor_r4", XOR_, 3'd4, 3'd1, 3'd2, 16'h0, 16'h0FFF, 1'b0, 1'b0);

    // Arithmetic
    run("ldi_ffff", LDI, 3'd1, 3'd0, 3'd0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
    run("ldi_0001", LDI, 3'd2, 3'd0, 3'd0, 16'h0001, 16'h0001, 1'b0, 1'b0);
    run("add",      ADD, 3'd4, 3'd1, 3'd2, 16'h0, 16'h0000, 1'b1, 1'b1);
    run("sub",      SUB, 3'd5, 3'd2, 3'd1, 16'h0, 16'h0002, 1'b0, 1'b1);
    run("sub_nb",   SUB, 3'd5, 3'd1, 3'd2, 16'h0, 16'hFFFE, 1'b0, 1'b0);
    run("ldi_8000", LDI, 3'd6, 3'd0, 3'd0, 16'h8000, 16'h8000, 1'b0, 1'b0);
    run("slt_neg",  SLT, 3'd7, 3'd6, 3'd2, 16'h0, 16'h0001, 1'b0, 1'b0);
    run("slt_pos",  SLT, 3'd7, 3'd2, 3'd6, 16'h0, 16'h0000, 1'b1, 1'b0);
    run("ldi_4",    LDI, 3'd3, 3'd0, 3'd0, 16'h0004, 16'h0004, 1'b0, 1'b0);
    run("sll4",     SLL, 3'd4, 3'd2, 3'd3, 16'h0, 16'h0010, 1'b0, 1'b0);
    run("ldi_14",   LDI, 3'd5, 3'd0, 3'd0, 16'h0014, 16'h0014, 1'b0, 1'b0);
    run("sll_b30",  SLL, 3'd7, 3'd1, 3'd5, 16'h0, 16'hFFF0, 1'b0, 1'b0);
    run("and_sign", AND_, 3'd7, 3'd1, 3'd6, 16'h0, 16'h8000, 1'b0, 1'b0);

    // R0 write discarded
    run("ldi_r0", LDI, 3'd0, 3'd0, 3'd0, 16'h1234, 16'h1234, 1'b0, 1'b0);
    @(negedge clk);
    dbg("dbg_r0", 3'd0, 16'h0000);
    run("or_r0r0", OR_, 3'd5, 3'd0, 3'd0, 16'h0, 16'h0000, 1'b1, 1'b0);
    @(negedge clk);

    // Handshake: valid held high, fields change every cycle
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      op = LDI; rd = k[2:0]; rs = 3'd0; rt = 3'd0; imm = 16'hA000 + k[15:0];
      instr_valid = 1'b1;
      chk("hs_ready", {31'h0, instr_ready}, {31'h0, ((k - 1) % 4) == 0});
      chk("hs_rv",    {31'h0, result_valid}, {31'h0, (k % 4) == 0});
    end
    @(negedge clk);
    instr_valid = 1'b0;
    dbg("hs_r1", 3'd1, 16'hA001);
    dbg("hs_r2", 3'd2, 16'h0001);
    dbg("hs_r3", 3'd3, 16'h0004);
    dbg("hs_r4", 3'd4, 16'h0010);
    dbg("hs_r5", 3'd5, 16'hA005);
    dbg("hs_r6", 3'd6, 16'h8000);
    dbg("hs_r0", 3'd0, 16'h0000);

    // Abort during EXEC
    @(negedge clk);
    op = LDI; rd = 3'd6; imm = 16'hBEEF; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_rv",    {31'h0, result_valid}, 32'd0);
    chk("abort_ready", {31'h0, instr_ready}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_idle_ready", {31'h0, instr_ready}, 32'd1);
    chk("abort_rv2",   {31'h0, result_valid}, 32'd0);
    dbg("abort_r6", 3'd6, 16'h0000);
    dbg("abort_r1", 3'd1, 16'h0000);
    chk("abort_result", {16'h0, result}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("abort_quiet", {31'h0, result_valid}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
